// File: rtl/ts_packet_sync_pkg.sv
// Shared MPEG-TS constants and sync-recovery state encoding, used by the
// packet sync front end and by the downstream monitor/replacer blocks.
package ts_packet_sync_pkg;

  localparam int         PACK_BYTE_SIZE = 188;
  localparam logic [7:0] SYNC_BYTE      = 8'h47;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_packet_sync.sv
// MPEG-TS packet alignment recovery: hunts for the sync byte, verifies it at
// packet spacing, then forwards aligned bytes with a start-of-packet strobe.
module ts_packet_sync #(
  parameter int         C_S_AXI_DATA_WIDTH = 32,
  parameter int         PACK_BYTE_SIZE     = ts_packet_sync_pkg::PACK_BYTE_SIZE,
  parameter logic [7:0] SYNC_BYTE          = ts_packet_sync_pkg::SYNC_BYTE,
  parameter int         LOCK_COUNT         = 3,
  parameter int         UNLOCK_COUNT       = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  input  logic                          cnt_clear,
  output logic [7:0]                    mpeg_data,
  output logic                          mpeg_valid,
  output logic                          mpeg_sync,
  output logic                          sync_err,
  output logic                          locked,
  output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0] sync_err_count
);

  import ts_packet_sync_pkg::*;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [7:0]                    LAST_BYTE = 8'(PACK_BYTE_SIZE - 1);
  localparam logic [GW-1:0]                 LOCK_N    = GW'(LOCK_COUNT);
  localparam logic [MW-1:0]                 UNLOCK_N  = MW'(UNLOCK_COUNT);
  localparam logic [GW-1:0]                 GOOD_ONE  = GW'(1);
  localparam logic [MW-1:0]                 MISS_ONE  = MW'(1);
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE   = C_S_AXI_DATA_WIDTH'(1);

  ts_state_e     state;
  logic [7:0]    byte_cnt;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;

  logic          is_sync;
  logic          at_byte0;
  logic [7:0]    byte_cnt_nx;
  logic [GW-1:0] good_inc;
  logic [MW-1:0] miss_inc;
  logic          reach_lock;
  logic          sync_miss;
  logic          drop_lock;
  logic          fwd_byte;
  logic          fwd_sync;

  // Decisions for the current byte are shared by the FSM and the counters so
  // that a counter increment always lines up with the byte it accounts for.
  always_comb begin
    is_sync     = (in_data == SYNC_BYTE);
    at_byte0    = (byte_cnt == '0);
    byte_cnt_nx = (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 8'd1;
    good_inc    = good_cnt + GOOD_ONE;
    miss_inc    = miss_cnt + MISS_ONE;
    reach_lock  = 1'b0;
    case (state)
      HUNT:    reach_lock = is_sync && (LOCK_COUNT == 1);
      VERIFY:  reach_lock = at_byte0 && is_sync && (good_inc == LOCK_N);
      default: reach_lock = 1'b0;
    endcase
    sync_miss = (state == LOCKED) && at_byte0 && !is_sync;
    drop_lock = sync_miss && (miss_inc == UNLOCK_N);
    fwd_byte  = in_valid && (reach_lock || ((state == LOCKED) && !drop_lock));
    fwd_sync  = fwd_byte && (reach_lock || at_byte0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      byte_cnt   <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      locked     <= 1'b0;
      mpeg_data  <= '0;
      mpeg_valid <= 1'b0;
      mpeg_sync  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      mpeg_valid <= fwd_byte;
      mpeg_sync  <= fwd_sync;
      sync_err   <= fwd_sync && sync_miss;
      if (fwd_byte)
        mpeg_data <= in_data;

      if (in_valid) begin
        case (state)
          HUNT: begin
            if (is_sync) begin
              byte_cnt <= 8'd1;
              good_cnt <= GOOD_ONE;
              state    <= reach_lock ? LOCKED : VERIFY;
              locked   <= reach_lock;
            end else begin
              byte_cnt <= '0;
            end
          end
          VERIFY: begin
            byte_cnt <= byte_cnt_nx;
            if (at_byte0) begin
              if (!is_sync) begin
                // A wrong byte at the expected sync slot restarts the hunt
                // from the following byte; it is not itself a candidate.
                state    <= HUNT;
                byte_cnt <= '0;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_inc;
                if (reach_lock) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            byte_cnt <= byte_cnt_nx;
            if (at_byte0)
              miss_cnt <= is_sync ? '0 : miss_inc;
            if (drop_lock) begin
              state    <= HUNT;
              locked   <= 1'b0;
              byte_cnt <= '0;
              good_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          default: begin
            state    <= HUNT;
            locked   <= 1'b0;
            byte_cnt <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Status counters; a clear pulse takes priority over any same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count      <= '0;
      sync_err_count <= '0;
    end else if (cnt_clear) begin
      pkt_count      <= '0;
      sync_err_count <= '0;
    end else begin
      if (fwd_sync)
        pkt_count <= pkt_count + CNT_ONE;
      if (in_valid && sync_miss && (sync_err_count != '1))
        sync_err_count <= sync_err_count + CNT_ONE;
    end
  end

endmodule
